// File: rtl/uart_tx_frame_engine.sv
// rtl/uart_tx_frame_engine.sv - UART transmit framer: start, 5..MAX_DATA_W data bits, optional parity, 1 or 2 stop bits
module uart_tx_frame_engine #(
    parameter int MAX_DATA_W = 9,
    parameter int DIV_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_W-1:0]      divider_i,
    input  logic [4:0]            frame_len_i,
    input  logic [1:0]            parity_mode_i,
    input  logic                  dstop_i,
    input  logic                  flow_control_i,
    input  logic                  cts_n_i,
    input  logic [MAX_DATA_W-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  frame_done_o
);

    localparam int         CNT_W   = $clog2(MAX_DATA_W + 1);
    localparam logic [4:0] MAX_LEN = 5'(MAX_DATA_W);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        DSTOP
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      baud_q, baud_d;
    logic [DIV_W-1:0]      div_q;
    logic [CNT_W-1:0]      bit_q, bit_d;
    logic [CNT_W-1:0]      len_q;
    logic [MAX_DATA_W-1:0] shift_q, shift_d;
    logic                  par_en_q, par_bit_q, dstop_q;
    logic                  tx_q, tx_d;
    logic                  cts_meta_n, cts_sync_n;

    logic [4:0]            len_eff;
    logic [MAX_DATA_W-1:0] len_mask;
    logic                  par_calc;
    logic                  par_bit;
    logic                  take;
    logic                  bit_end;

    // CTS is asynchronous to clk; only the second flop is ever looked at
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cts_meta_n <= 1'b1;
            cts_sync_n <= 1'b1;
        end else begin
            cts_meta_n <= cts_n_i;
            cts_sync_n <= cts_meta_n;
        end
    end

    assign ready_o = !rst && (state_q == IDLE) && (!flow_control_i || !cts_sync_n);
    assign take    = valid_i && ready_o;
    assign bit_end = (baud_q == '0);

    // Clamp length and compute parity over only the N live data bits
    always_comb begin
        len_mask = '0;
        if (frame_len_i < 5'd5) begin
            len_eff = 5'd5;
        end else if (frame_len_i > MAX_LEN) begin
            len_eff = MAX_LEN;
        end else begin
            len_eff = frame_len_i;
        end
        for (int i = 0; i < MAX_DATA_W; i++) begin
            len_mask[i] = (5'(i) < len_eff);
        end
        par_calc = ^(data_i & len_mask);
        case (parity_mode_i)
            2'b01:   par_bit = par_calc;
            2'b10:   par_bit = ~par_calc;
            2'b11:   par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;

        if (state_q != IDLE) begin
            baud_d = bit_end ? div_q : baud_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (take) begin
                    state_d = START;
                    tx_d    = 1'b0;
                    baud_d  = divider_i;
                    shift_d = data_i;
                    bit_d   = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == len_q - CNT_W'(1)) begin
                        state_d = par_en_q ? PARITY : STOP;
                        tx_d    = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                        bit_d   = bit_q + CNT_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = dstop_q ? DSTOP : IDLE;
                    tx_d    = 1'b1;
                end
            end
            DSTOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // Frame configuration is frozen at the handshake so CSR writes mid-frame are harmless
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q     <= '0;
            len_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            dstop_q   <= 1'b0;
        end else if (take) begin
            div_q     <= divider_i;
            len_q     <= CNT_W'(len_eff);
            par_en_q  <= (parity_mode_i != 2'b00);
            par_bit_q <= par_bit;
            dstop_q   <= dstop_i;
        end
    end

    assign tx_o         = tx_q;
    assign busy_o       = (state_q != IDLE);
    assign frame_done_o = bit_end && (((state_q == STOP) && !dstop_q) || (state_q == DSTOP));

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// tb/tb_uart_tx_frame_engine.sv - scoreboard bench for uart_tx_frame_engine
`timescale 1ns/1ps
module tb_uart_tx_frame_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] divider_i;
    logic [4:0]  frame_len_i;
    logic [1:0]  parity_mode_i;
    logic        dstop_i;
    logic        flow_control_i;
    logic        cts_n_i;
    logic [8:0]  data_i;
    logic        valid_i;
    logic        ready_o;
    logic        tx_o;
    logic        busy_o;
    logic        frame_done_o;

    int checks = 0;
    int errors = 0;

    string exp_bits_q[$];
    int    exp_div_q[$];
    int    exp_gap_q[$];
    bit    exp_abort_q[$];

    uart_tx_frame_engine #(.MAX_DATA_W(9), .DIV_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .divider_i      (divider_i),
        .frame_len_i    (frame_len_i),
        .parity_mode_i  (parity_mode_i),
        .dstop_i        (dstop_i),
        .flow_control_i (flow_control_i),
        .cts_n_i        (cts_n_i),
        .data_i         (data_i),
        .valid_i        (valid_i),
        .ready_o        (ready_o),
        .tx_o           (tx_o),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [8:0] d, input int dv, input logic [4:0] fl,
                        input logic [1:0] pm, input logic ds, input string bits,
                        input int gap, input bit abort);
        bit got;
        exp_bits_q.push_back(bits);
        exp_div_q.push_back(dv);
        exp_gap_q.push_back(gap);
        exp_abort_q.push_back(abort);
        divider_i     = 16'(dv);
        frame_len_i   = fl;
        parity_mode_i = pm;
        dstop_i       = ds;
        data_i        = d;
        valid_i       = 1'b1;
        #1;
        got = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (ready_o) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL send_ready_timeout: data %0h never accepted", d);
        end else begin
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (!busy_o && exp_bits_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy %b pending %0d", busy_o, exp_bits_q.size());
        end
    endtask

    // Monitor: detect each frame start, pop its expectation, check every bit period
    initial begin : monitor
        string s;
        int    dv, gp, gap_cnt, frame_no;
        bit    ab, aborted, bad, fd_exp, exp_b, prev_busy;
        logic  bad_tx, bad_fd, bad_busy;
        prev_busy = 1'b0;
        gap_cnt   = 0;
        frame_no  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0;
                gap_cnt   = 0;
                continue;
            end
            if (busy_o && !prev_busy) begin
                if (exp_bits_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame: busy rose with empty scoreboard");
                end else begin
                    s  = exp_bits_q.pop_front();
                    dv = exp_div_q.pop_front();
                    gp = exp_gap_q.pop_front();
                    ab = exp_abort_q.pop_front();
                    if (gp >= 0) begin
                        checks++;
                        if (gap_cnt != gp) begin
                            errors++;
                            $display("FAIL frame%0d_gap: got %0d idle clocks expected %0d", frame_no, gap_cnt, gp);
                        end
                    end
                    aborted = 1'b0;
                    for (int i = 0; i < s.len(); i++) begin
                        exp_b = (s[i] == 8'h31);
                        bad = 1'b0;
                        bad_tx = 1'b0; bad_fd = 1'b0; bad_busy = 1'b0;
                        for (int c = 0; c <= dv; c++) begin
                            if (i != 0 || c != 0) @(negedge clk);
                            if (rst) begin
                                aborted = 1'b1;
                                break;
                            end
                            fd_exp = (i == s.len() - 1) && (c == dv);
                            if (!bad && (tx_o !== exp_b || frame_done_o !== fd_exp || busy_o !== 1'b1)) begin
                                bad = 1'b1;
                                bad_tx = tx_o; bad_fd = frame_done_o; bad_busy = busy_o;
                                $display("FAIL frame%0d_bit%0d: tx/done/busy got %b/%b/%b expected %b/%b/1 at clk %0d",
                                         frame_no, i, bad_tx, bad_fd, bad_busy, exp_b, fd_exp, c);
                            end
                        end
                        if (aborted) break;
                        checks++;
                        if (bad) errors++;
                    end
                    checks++;
                    if (aborted != ab) begin
                        errors++;
                        $display("FAIL frame%0d_abort: got %b expected %b", frame_no, aborted, ab);
                    end
                    frame_no++;
                end
                gap_cnt = 0;
            end else if (!busy_o) begin
                gap_cnt++;
                if (frame_done_o) begin
                    checks++;
                    errors++;
                    $display("FAIL idle_frame_done: got 1 expected 0");
                end
            end
            prev_busy = busy_o && !rst;
        end
    end

    initial begin : stimulus
        bit   held_ok;
        int   lat;
        rst            = 1'b1;
        divider_i      = 16'd0;
        frame_len_i    = 5'd8;
        parity_mode_i  = 2'b00;
        dstop_i        = 1'b0;
        flow_control_i = 1'b0;
        cts_n_i        = 1'b1;
        data_i         = 9'h000;
        valid_i        = 1'b0;

        repeat (3) @(negedge clk);
        chk("reset_tx", 32'(tx_o), 32'd1);
        chk("reset_busy", 32'(busy_o), 32'd0);
        chk("reset_ready", 32'(ready_o), 32'd0);
        chk("reset_frame_done", 32'(frame_done_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        send(9'h055, 3, 5'd8, 2'b00, 1'b0, "0101010101", -1, 1'b0);
        wait_idle();

        send(9'h041, 0, 5'd7, 2'b01, 1'b0, "0100000101", -1, 1'b0);
        send(9'h041, 0, 5'd7, 2'b10, 1'b0, "0100000111", -1, 1'b0);
        send(9'h041, 0, 5'd7, 2'b11, 1'b0, "0100000111", -1, 1'b0);
        send(9'h041, 0, 5'd7, 2'b01, 1'b1, "01000001011", -1, 1'b0);
        wait_idle();

        send(9'h1FF, 1, 5'd9, 2'b01, 1'b0, "011111111111", -1, 1'b0);
        send(9'h0FF, 1, 5'd3, 2'b01, 1'b0, "01111111", -1, 1'b0);
        send(9'h100, 1, 5'd20, 2'b00, 1'b0, "00000000011", -1, 1'b0);
        wait_idle();

        send(9'h0A5, 1, 5'd8, 2'b00, 1'b0, "0101001011", -1, 1'b0);
        send(9'h03C, 2, 5'd6, 2'b00, 1'b0, "00011111", 1, 1'b0);
        wait_idle();

        flow_control_i = 1'b1;
        cts_n_i        = 1'b1;
        divider_i      = 16'd1;
        frame_len_i    = 5'd8;
        parity_mode_i  = 2'b00;
        dstop_i        = 1'b0;
        data_i         = 9'h096;
        valid_i        = 1'b1;
        exp_bits_q.push_back("0011010011");
        exp_div_q.push_back(1);
        exp_gap_q.push_back(-1);
        exp_abort_q.push_back(1'b0);
        held_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ready_o !== 1'b0 || tx_o !== 1'b1) held_ok = 1'b0;
        end
        chk("cts_hold_off", 32'(held_ok), 32'd1);
        cts_n_i = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (ready_o) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat < 2 || lat > 3) begin
            errors++;
            $display("FAIL cts_ready_latency: got %0d clocks expected 2..3", lat);
        end
        if (lat != 0) @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (6) @(negedge clk);
        cts_n_i = 1'b1;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("cts_blocked_ready", 32'(ready_o), 32'd0);
        flow_control_i = 1'b0;
        @(negedge clk);

        send(9'h0F0, 1, 5'd8, 2'b00, 1'b0, "0000011111", -1, 1'b1);
        repeat (9) @(negedge clk);
        chk("pre_reset_tx_bit3", 32'(tx_o), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_reset_tx", 32'(tx_o), 32'd1);
        chk("mid_reset_busy", 32'(busy_o), 32'd0);
        chk("mid_reset_ready", 32'(ready_o), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(9'h00F, 1, 5'd8, 2'b00, 1'b0, "0111100001", -1, 1'b0);
        wait_idle();

        chk("scoreboard_drained", 32'(exp_bits_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame_engine.md
Name: uart_tx_frame_engine

Overview:
Parametrised UART transmit framer: serialises one data word per handshake into start / data / optional parity / one or two stop bits on the TX line.
- Supports a runtime frame length of 5..MAX_DATA_W bits, four parity modes, and optional CTS flow control.
- Sits between the TX FIFO and the TX pad; the divider and config fields come from the CSR block (DIVIDER, CONTROL).

Parameters:
MAX_DATA_W, 9, maximum data bits per frame (legal 5..16)
DIV_W, 16, width of baud divider

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
divider_i  in  DIV_W  bit period minus one, in clk cycles
frame_len_i  in  5  data bits per frame
parity_mode_i  in  2  00 none, 01 even, 10 odd, 11 mark (constant 1)
dstop_i  in  1  1 = two stop bits
flow_control_i  in  1  1 = gate frame start on CTS
cts_n_i  in  1  asynchronous CTS, active-low
data_i  in  MAX_DATA_W  word to send, LSB first
valid_i  in  1  data_i valid
ready_o  out  1  engine accepts a word this cycle
tx_o  out  1  serial line, idle high
busy_o  out  1  frame in progress
frame_done_o  out  1  one-cycle pulse at end of final stop bit

Behaviour:
Reset (async, immediate):
- tx_o=1, busy_o=0, ready_o=0, frame_done_o=0; state=IDLE.
- Baud counter, bit counter and shift register cleared.
- CTS synchroniser flops reset to 1 (CTS inactive).
- Reset mid-frame aborts the frame; tx_o returns high in the same cycle reset asserts.

CTS:
- cts_n_i passes through a 2-flop synchroniser; only the synchronised value is used.

Handshake:
- ready_o = (state==IDLE) && (!flow_control_i || !cts_sync_n). It is registered-state based, with no combinational path from valid_i.
- Transfer occurs on a rising edge with valid_i && ready_o.
- At transfer, latch into internal registers: data_i, the effective length, parity_mode_i, dstop_i, divider_i. Config changes during a frame have no effect.

Effective length N:
- frame_len_i < 5 → 5.
- frame_len_i > MAX_DATA_W → MAX_DATA_W.
- Otherwise frame_len_i.

States: IDLE, START, DATA, PARITY, STOP, DSTOP. Every non-IDLE state lasts exactly divider+1 clocks. divider=0 gives 1 clock per bit; no special case.
- IDLE → START on transfer. tx_o=0 from the cycle after the transfer edge (tx_o is registered).
- START → DATA. tx_o = data bit 0.
- DATA: shift right each bit period; after bit N-1 → PARITY if mode≠00, else STOP.
- PARITY: tx_o = XOR of the N data bits for even, its inverse for odd, 1 for mark. Bits above N do not count.
- STOP: tx_o=1. → DSTOP if dstop latched, else IDLE.
- DSTOP: tx_o=1, → IDLE.

Outputs and timing:
- frame_done_o pulses in the last clock of the final stop bit.
- busy_o=1 in all states except IDLE.
- Frame duration = (1+N+P+S)·(divider+1) clocks, where P∈{0,1} and S∈{1,2}.
- Minimum inter-frame gap is 1 idle clock at tx_o=1. Back-to-back valid_i is accepted on the first IDLE cycle.

Flow control:
- CTS deassertion mid-frame never aborts or stretches the current frame.
- CTS is only evaluated in IDLE.
- flow_control_i=0 ignores CTS entirely.

Counters:
- Baud counter counts down from the latched divider to 0 and reloads on each bit boundary.
- Bit counter width is ceil(log2(MAX_DATA_W+1)).

Test Plan:
- divider=3, N=8, parity none, 1 stop, data 0x55 → tx_o low 4 clk, then bits 1,0,1,0,1,0,1,0, then stop high 4 clk; frame_done_o at clock 40 after the transfer edge; busy_o high for 40 clocks.
- divider=0, N=7, even parity, data 0x41 → parity bit 0. With odd parity → 1. With mark → 1. Frame is 10 clocks; with dstop=1 it is 11 clocks.
- MAX_DATA_W=9, frame_len=9, data 0x1FF, even parity → nine 1s then parity 1. Then frame_len=3, data 0xFF → exactly 5 data bits sent (clamped).
- flow_control=1, cts_n_i=1, valid_i=1 → ready_o stays 0 and tx_o stays 1. cts_n_i falls → ready_o rises 2–3 clocks later and the frame starts. Raising cts_n mid-frame → frame completes unchanged.
- Back-to-back: valid_i held with 0xA5 then 0x3C, divider=1 → second START begins exactly 1 idle clock after the first frame_done_o. Changing divider_i or frame_len_i mid-frame leaves the first frame unaffected.
- Assert rst during DATA bit 3 → tx_o=1, busy_o=0 in the same cycle. After release, a fresh 0x0F frame transmits correctly from START.
